// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the timing generator to pixel-colour consumers
interface vga_timing_gen_if;
  logic       pix_ce;
  logic       hsync;
  logic       vsync;
  logic       blank_n;
  logic [8:0] row;
  logic [9:0] column;
  logic       frame_tick;
  modport master (output pix_ce, hsync, vsync, blank_n, row, column, frame_tick);
  modport slave  (input  pix_ce, hsync, vsync, blank_n, row, column, frame_tick);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing (pixel enable, syncs, blank, coordinates, frame tick).
// Define VGA_PIPE_ALIGN_EN to delay hsync/vsync/blank_n/frame_tick by one extra pixel stage.
module vga_timing_gen #(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic              clk,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_chk
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_div_chk
    $error("vga_timing_gen: CLK_DIV must be in 1..8");
  end
  logic [2:0] div_cnt;
  logic [9:0] h_cnt, v_cnt;
  logic       pix_ce, frame_tick, hs1, vs1, bn1;
  logic [8:0] row;
  logic [9:0] column;
  logic       div_last, h_last, v_last, hs_d, vs_d, bn_d, ft_d, ft_src;
  int         h_i, v_i;
  always_comb begin
    h_i      = int'(h_cnt);
    v_i      = int'(v_cnt);
    div_last = div_cnt == 3'(CLK_DIV - 1);
    h_last   = h_i == H_TOTAL - 1;
    v_last   = v_i == V_TOTAL - 1;
    hs_d     = !(h_i >= H_VIS + H_FP && h_i < H_VIS + H_FP + H_SYNC);
    vs_d     = !(v_i >= V_VIS + V_FP && v_i < V_VIS + V_FP + V_SYNC);
    bn_d     = h_i < H_VIS && v_i < V_VIS;
    ft_d     = h_i == 0 && v_i == V_VIS;
  end
  // Outputs capture the decode of the current counters, so they trail the counters by one pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= '0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      pix_ce     <= 1'b0;
      frame_tick <= 1'b0;
      hs1        <= 1'b1;
      vs1        <= 1'b1;
      bn1        <= 1'b0;
      row        <= '0;
      column     <= '0;
    end else begin
      div_cnt    <= div_last ? '0 : div_cnt + 3'd1;
      pix_ce     <= div_last;
      frame_tick <= pix_ce && ft_src;
      if (pix_ce) begin
        hs1    <= hs_d;
        vs1    <= vs_d;
        bn1    <= bn_d;
        row    <= v_cnt[8:0];
        column <= h_cnt;
        h_cnt  <= h_last ? '0 : h_cnt + 10'd1;
        if (h_last) v_cnt <= v_last ? '0 : v_cnt + 10'd1;
      end
    end
  end
`ifdef VGA_PIPE_ALIGN_EN
  // Extra stage matches the registered board-RAM read feeding the colour path.
  logic hs2, vs2, bn2, ft1;
  always_ff @(posedge clk) begin
    if (reset) begin
      hs2 <= 1'b1;
      vs2 <= 1'b1;
      bn2 <= 1'b0;
      ft1 <= 1'b0;
    end else if (pix_ce) begin
      hs2 <= hs1;
      vs2 <= vs1;
      bn2 <= bn1;
      ft1 <= ft_d;
    end
  end
  assign ft_src      = ft1;
  assign vga.hsync   = hs2;
  assign vga.vsync   = vs2;
  assign vga.blank_n = bn2;
`else
  assign ft_src      = ft_d;
  assign vga.hsync   = hs1;
  assign vga.vsync   = vs1;
  assign vga.blank_n = bn1;
`endif
  assign vga.pix_ce     = pix_ce;
  assign vga.row        = row;
  assign vga.column     = column;
  assign vga.frame_tick = frame_tick;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of raster timing on a narrow-line build (15-pixel lines, 525 lines).
module tb_vga_timing_gen;
  localparam int HV = 8, HF = 2, HS = 3, HB = 2, HT = 15, VV = 480, VT = 525;
  localparam int FP = HT * VT;
  localparam int NP = 2 * FP + 200 * HT + 6;
`ifdef VGA_PIPE_ALIGN_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif
  localparam logic [23:0] RST = 24'h600000;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  vga_timing_gen_if a_if();
  vga_timing_gen_if b_if();
  vga_timing_gen #(.CLK_DIV(2), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB)) dut_a (.clk(clk), .reset(reset), .vga(a_if));
  vga_timing_gen #(.CLK_DIV(1), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB)) dut_b (.clk(clk), .reset(reset), .vga(b_if));
  logic [23:0] va, vb;
  assign va = {a_if.pix_ce, a_if.hsync, a_if.vsync, a_if.blank_n, a_if.frame_tick, a_if.row, a_if.column};
  assign vb = {b_if.pix_ce, b_if.hsync, b_if.vsync, b_if.blank_n, b_if.frame_tick, b_if.row, b_if.column};
  int checks = 0, failures = 0;
  int cyc = 0, ticks = 0, ft_hi = 0, t0 = 0, t1 = 0, tick_row = -1, tick_col = -1;
  int b_pce_low = 0, b_fall_col = -1, b_tick_col = -1, b_tick_row = -1;
  bit ft_prev = 1'b0, bn_b_prev = 1'b0, b_run = 1'b0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic pixel_a(output bit ok);
    int n = 0;
    while (!a_if.pix_ce && n < 16) begin
      @(negedge clk);
      n++;
    end
    ok = a_if.pix_ce;
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    cyc++;
    if (a_if.frame_tick) begin
      ft_hi++;
      if (!ft_prev) begin
        ticks++;
        if (ticks == 1) begin
          t0 = cyc;
          tick_row = int'(a_if.row);
          tick_col = int'(a_if.column);
        end else if (ticks == 2) t1 = cyc;
      end
    end
    ft_prev = a_if.frame_tick;
    if (b_run) begin
      if (!b_if.pix_ce) b_pce_low++;
      if (bn_b_prev && !b_if.blank_n && b_fall_col < 0) b_fall_col = int'(b_if.column);
      if (b_if.frame_tick && b_tick_col < 0) begin
        b_tick_col = int'(b_if.column);
        b_tick_row = int'(b_if.row);
      end
    end
    bn_b_prev = b_if.blank_n;
  end
  initial begin
    bit ok;
    logic [3:0] pat;
    int ln, cl, fl, rc_err = 0, bfall = -1, hs_low = 0, hs_first = -1, vs_low = 0, vs_first = -1, bn_low = 0;
    repeat (5) @(negedge clk);
    check("rst_a", 32'(va), 32'(RST));
    check("rst_b", 32'(vb), 32'(RST));
    reset = 1'b0;
    @(negedge clk); pat[3] = a_if.pix_ce;
    @(negedge clk); pat[2] = a_if.pix_ce;
    @(negedge clk); pat[1] = a_if.pix_ce;
    check("first_rc", 32'({a_if.row, a_if.column}), 0);
    check("first_bn", 32'(a_if.blank_n), 1 - LAG);
    check("first_sync", 32'({a_if.hsync, a_if.vsync}), 3);
    @(negedge clk); pat[0] = a_if.pix_ce;
    check("pce_pat", 32'(pat), 32'h5);
    b_run = 1'b1;
    for (int p = 1; p < NP; p++) begin
      pixel_a(ok);
      if (!ok) begin
        check("pix_timeout", 0, 1);
        break;
      end
      ln = p / HT;
      cl = p % HT;
      fl = ln % VT;
      if (int'(a_if.column) != cl || int'(a_if.row) != fl % 512) rc_err++;
      if (ln == 1) begin
        if (!a_if.blank_n && bfall < 0) bfall = cl;
        if (!a_if.hsync) begin
          hs_low++;
          if (hs_first < 0) hs_first = cl;
        end
      end
      if (ln / VT == 1) begin
        if (!a_if.vsync) begin
          vs_low++;
          if (vs_first < 0) vs_first = fl;
        end
        if (!a_if.blank_n) bn_low++;
      end
      if (fl == 512 && cl == 0) check("alias512", 32'({a_if.row, a_if.blank_n, a_if.frame_tick}), 0);
      if (fl == VV && cl == LAG) check("tick_at_480", 32'(a_if.frame_tick), 1);
    end
    check("row_col_seq_err", rc_err, 0);
    check("blank_fall_col", bfall, HV + LAG);
    check("hsync_low_px", hs_low, HS);
    check("hsync_first_col", hs_first, HV + HF + LAG);
    check("vsync_low_px", vs_low, 2 * HT);
    check("vsync_first_row", vs_first, 490);
    check("blank_low_px", bn_low, 4035);
    check("pre_rst_pos", 32'({a_if.row, a_if.column}), 32'({9'd200, 10'd5}));
    b_run = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_a", 32'(va), 32'(RST));
    reset = 1'b0;
    pixel_a(ok);
    check("post_rst_ok", 32'(ok), 1);
    check("post_rst_rc", 32'({a_if.row, a_if.column}), 0);
    check("post_rst_bn", 32'(a_if.blank_n), 1 - LAG);
    check("tick_count", ticks, 2);
    check("tick_width", ft_hi, 2);
    check("tick_period", t1 - t0, 2 * FP);
    check("tick_row", tick_row, VV);
    check("tick_col", tick_col, LAG);
    check("b_pce_low", b_pce_low, 0);
    check("b_blank_fall_col", b_fall_col, HV + LAG);
    check("b_tick_col", b_tick_col, LAG);
    check("b_tick_row", b_tick_row, VV);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
